// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style main controller for a multicycle MIPS datapath. It steps the
// shared ALU, memory, IR, register file and PC through the fetch, decode,
// execute, memory and write-back phases. It also drives the 3-bit ALUOp that
// the ALU control decoder consumes.
//
// Every output except IllegalOp is a pure function of the current state, the
// IR opcode/funct fields and the ALU Zero flag. IllegalOp is a registered,
// sticky flag that only reset clears.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   Opcode     in   IR[31:26], stable from DECODE onward
//   Funct      in   IR[5:0]
//   Zero       in   ALU zero flag (used only in BRANCH)
//   PCWrite    out  final PC enable, branch condition already resolved
//   IorD       out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead    out  memory read strobe
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register load
//   RegWrite   out  register file write
//   RegDst     out  00 = rt, 01 = rd, 10 = $31
//   MemtoReg   out  00 = ALUOut, 01 = MDR, 10 = PC
//   ALUSrcA    out  0 = PC, 1 = A
//   ALUSrcB    out  00 = B, 01 = 4, 10 = ext(imm), 11 = signext(imm)<<2
//   ExtSel     out  0 = sign-extend, 1 = zero-extend
//   PCSource   out  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A
//   ALUOp      out  000 add, 001 sub, 111 R-type, 100 and, 101 or, 011 lui
//   IllegalOp  out  sticky undecodable-opcode flag
//   State      out  current state encoding (debug)
//
// Handshake note: there is no valid/ready handshake. The controller advances
// one state per clock. Memory and the register file are assumed to complete
// within the cycle in which their strobes are asserted.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int unsigned RESET_STATE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtSel,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_MEM_ADDR   = 4'd3,
        S_MEM_READ   = 4'd4,
        S_MEM_WB     = 4'd5,
        S_MEM_WRITE  = 4'd6,
        S_EXECUTE    = 4'd7,
        S_R_COMPLETE = 4'd8,
        S_BRANCH     = 4'd9,
        S_JUMP       = 4'd10,
        S_JAL        = 4'd11,
        S_I_EXECUTE  = 4'd12,
        S_I_COMPLETE = 4'd13,
        S_JR         = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // The reset counter's compare value is the number of S_RESET cycles
    // minus one, because the last counted cycle is also the exit cycle.
    localparam logic [3:0] RST_LAST = 4'(RESET_STATE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] rst_cnt_q, rst_cnt_d;
    logic       illegal_q, illegal_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RESET;
            rst_cnt_q <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = 4'd0;
        illegal_d = illegal_q;

        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtSel   = 1'b0;
        PCSource = 2'b00;
        ALUOp    = 3'b000;

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q >= RST_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end

            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = S_DECODE;
            end

            // The branch target is computed here speculatively into ALUOut.
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE:       state_d = (Funct == FN_JR) ? S_JR : S_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXECUTE;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_FETCH;
            end

            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = S_FETCH;
            end

            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                state_d = S_R_COMPLETE;
            end

            S_R_COMPLETE: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                state_d  = S_FETCH;
            end

            // Only BEQ/BNE reach this state, so any opcode other than BNE
            // takes the BEQ sense.
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                PCWrite  = (Opcode == OP_BNE) ? ~Zero : Zero;
                state_d  = S_FETCH;
            end

            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end

            // PC already holds PC+4 from FETCH, which is the link value.
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                state_d  = S_FETCH;
            end

            S_I_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_ANDI: begin
                        ALUOp  = 3'b100;
                        ExtSel = 1'b1;
                    end
                    OP_ORI: begin
                        ALUOp  = 3'b101;
                        ExtSel = 1'b1;
                    end
                    OP_LUI:  ALUOp = 3'b011;
                    default: ALUOp = 3'b000;
                endcase
                state_d = S_I_COMPLETE;
            end

            S_I_COMPLETE: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end

            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end

            // Encoding 15 is unreachable. Recover quietly with all outputs 0.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign IllegalOp = illegal_q;
    assign State     = state_q;

endmodule
